// File: rtl/l0_loader.sv
// ---------------------------------------------------------------------------
// l0_loader
// Streams num_vec consecutive row*bw-bit words from the activation SRAM into
// the L0 buffer. One SRAM read is issued per cycle while L0 is ready; the L0
// write strobe is raised in the same cycle as the read, because L0 registers
// wr internally and so consumes sram_dout one cycle later, when it is valid.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle load request (accepted in IDLE only)
//   base_addr         first SRAM address, latched on accepted start
//   num_vec           number of words to move, latched on accepted start
//   l0_ready          L0 can accept a write this cycle
//   sram_dout         SRAM read data (valid one cycle after a read)
//   sram_cen          SRAM chip enable, active-low
//   sram_wen          SRAM write enable, active-low (always high: read only)
//   sram_addr         SRAM address
//   l0_wr             L0 write strobe
//   l0_in             L0 write data (straight from sram_dout)
//   busy              load in progress (LOAD, DRAIN)
//   done              one-cycle completion pulse
//
// The issue-side outputs are combinational from state and l0_ready: the
// issue decision has to see l0_ready in the same cycle, with no lookahead.
// ---------------------------------------------------------------------------
module l0_loader #(
   parameter int unsigned row = 8,
   parameter int unsigned bw  = 4,
   parameter int unsigned aw  = 11,
   parameter int unsigned lw  = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [aw-1:0]     base_addr,
   input  logic [lw-1:0]     num_vec,
   input  logic              l0_ready,
   input  logic [row*bw-1:0] sram_dout,
   output logic              sram_cen,
   output logic              sram_wen,
   output logic [aw-1:0]     sram_addr,
   output logic              l0_wr,
   output logic [row*bw-1:0] l0_in,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [aw-1:0] base_q,  base_d;
   logic [lw-1:0] num_q,   num_d;
   logic [lw-1:0] cnt_q,   cnt_d;
   logic          issue_c;

   // State and latched-request registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         base_q  <= '0;
         num_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and issue decision
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      num_d   = num_q;
      cnt_d   = cnt_q;
      issue_c = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && !reset) begin
               base_d  = base_addr;
               num_d   = num_vec;
               cnt_d   = '0;
               state_d = (num_vec != '0) ? LOAD : DONE;
            end
         end
         LOAD: begin
            // Leave one edge after the count is reached; the last issue's
            // data lands in the cycle spent here with cnt_q == num_q.
            if (cnt_q == num_q) begin
               state_d = DRAIN;
            end else if (l0_ready && (cnt_q < num_q) && !reset) begin
               issue_c = 1'b1;
               cnt_d   = cnt_q + lw'(1);
            end
         end
         DRAIN: state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs; reset forces the idle values even before the reset edge
   assign sram_cen  = ~issue_c;
   assign sram_wen  = 1'b1;
   assign sram_addr = reset ? '0 : aw'(base_q + aw'(cnt_q));
   assign l0_wr     = issue_c;
   assign l0_in     = sram_dout;
   assign busy      = !reset && ((state_q == LOAD) || (state_q == DRAIN));
   assign done      = !reset && (state_q == DONE);

endmodule
